// File: rtl/dm_port_arbiter.sv
// Shares one single-port data SRAM between the CPU MEM stage (fixed priority) and the AHB slave,
// with an aging counter so AHB cannot starve, and per-port read-data return with hold registers.
module dm_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ahb_req,
  input  logic              ahb_we,
  input  logic [ADDR_W-1:0] ahb_addr,
  input  logic [DATA_W-1:0] ahb_wdata,
  output logic              ahb_gnt,
  output logic              ahb_rvalid,
  output logic [DATA_W-1:0] ahb_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_we,
  input  logic [DATA_W-1:0] sram_dout
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AHB  = 2'd2
  } rd_owner_t;

  rd_owner_t         rd_owner_reg, rd_owner_next;
  logic [3:0]        starve_cnt_reg, starve_cnt_next;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] din_hold_reg;
  logic [DATA_W-1:0] cpu_hold_reg;
  logic [DATA_W-1:0] ahb_hold_reg;
  logic              force_ahb;

  // Grants are suppressed during reset so nothing reaches the SRAM.
  assign force_ahb = ahb_req & (starve_cnt_reg >= 4'(STARVE_MAX));
  assign ahb_gnt   = ~rst & ahb_req & (~cpu_req | force_ahb);
  assign cpu_gnt   = ~rst & cpu_req & ~ahb_gnt;
  assign cpu_stall = ~rst & cpu_req & ~cpu_gnt;

  always_comb begin
    sram_addr = addr_hold_reg;
    sram_din  = din_hold_reg;
    sram_we   = 1'b0;
    if (ahb_gnt) begin
      sram_addr = ahb_addr;
      sram_din  = ahb_wdata;
      sram_we   = ahb_we;
    end else if (cpu_gnt) begin
      sram_addr = cpu_addr;
      sram_din  = cpu_wdata;
      sram_we   = cpu_we;
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (ahb_gnt || !ahb_req) begin
      starve_cnt_next = 4'd0;
    end else if (starve_cnt_reg != 4'hF) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  always_comb begin
    rd_owner_next = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_next = OWN_CPU;
    end else if (ahb_gnt && !ahb_we) begin
      rd_owner_next = OWN_AHB;
    end
  end

  // rvalid is masked by rst so a read in flight when reset hits is never reported.
  assign cpu_rvalid = ~rst & (rd_owner_reg == OWN_CPU);
  assign ahb_rvalid = ~rst & (rd_owner_reg == OWN_AHB);
  assign cpu_rdata  = cpu_rvalid ? sram_dout : cpu_hold_reg;
  assign ahb_rdata  = ahb_rvalid ? sram_dout : ahb_hold_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= 4'd0;
      rd_owner_reg   <= OWN_NONE;
      cpu_hold_reg   <= '0;
      ahb_hold_reg   <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      rd_owner_reg   <= rd_owner_next;
      if (rd_owner_reg == OWN_CPU) begin
        cpu_hold_reg <= sram_dout;
      end
      if (rd_owner_reg == OWN_AHB) begin
        ahb_hold_reg <= sram_dout;
      end
    end
  end

  // Last driven address/data are held so idle cycles do not toggle the SRAM pins.
  always_ff @(posedge clk) begin
    if (cpu_gnt || ahb_gnt) begin
      addr_hold_reg <= sram_addr;
      din_hold_reg  <= sram_din;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized and directed bench for dm_port_arbiter: an SRAM model on the memory pins and a
// transaction-level reference model of arbitration, aging and read-data return.
module tb_dm_port_arbiter;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ahb_req, ahb_we;
  logic [ADDR_W-1:0] ahb_addr;
  logic [DATA_W-1:0] ahb_wdata;
  logic              ahb_gnt, ahb_rvalid;
  logic [DATA_W-1:0] ahb_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic              sram_we;
  logic [DATA_W-1:0] sram_dout;

  dm_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ahb_req(ahb_req), .ahb_we(ahb_we), .ahb_addr(ahb_addr), .ahb_wdata(ahb_wdata),
    .ahb_gnt(ahb_gnt), .ahb_rvalid(ahb_rvalid), .ahb_rdata(ahb_rdata),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we), .sram_dout(sram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write-first single-port SRAM with one cycle read latency.
  logic [DATA_W-1:0] sram_mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_addr] <= sram_din;
    sram_dout <= sram_we ? sram_din : sram_mem[sram_addr];
  end

  // Reference model state
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  int                denied;
  bit                cpu_pend, ahb_pend;
  logic [DATA_W-1:0] cpu_pend_data, ahb_pend_data, cpu_hold, ahb_hold;
  bit                last_valid;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_din;
  bit                verbose;

  // Values observed at the last sample point, for directed checks
  logic              obs_cpu_gnt, obs_ahb_gnt, obs_cpu_rvalid, obs_ahb_rvalid;
  logic [DATA_W-1:0] obs_cpu_rdata, obs_ahb_rdata;

  int n_tests;
  int n_fail;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic drive_ahb(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd);
    ahb_req = req; ahb_we = we; ahb_addr = addr; ahb_wdata = wd;
  endtask

  // Called just after a rising edge with inputs already driven; checks mid-cycle, then advances the model.
  task automatic cycle();
    bit e_cg, e_ag, e_we, e_crv, e_arv;
    #4;
    e_ag = !rst && ahb_req && (!cpu_req || denied >= STARVE_MAX);
    e_cg = !rst && cpu_req && !e_ag;
    e_we = (e_ag && ahb_we) || (e_cg && cpu_we);
    check_val("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
    check_val("ahb_gnt", 32'(ahb_gnt), 32'(e_ag));
    check_val("cpu_stall", 32'(cpu_stall), 32'(!rst && cpu_req && !e_cg));
    check_val("sram_we", 32'(sram_we), 32'(e_we));
    if (e_ag) begin
      check_val("sram_addr", 32'(sram_addr), 32'(ahb_addr));
      check_val("sram_din", sram_din, ahb_wdata);
    end else if (e_cg) begin
      check_val("sram_addr", 32'(sram_addr), 32'(cpu_addr));
      check_val("sram_din", sram_din, cpu_wdata);
    end else if (last_valid) begin
      check_val("sram_addr_held", 32'(sram_addr), 32'(last_addr));
      check_val("sram_din_held", sram_din, last_din);
    end
    e_crv = !rst && cpu_pend;
    e_arv = !rst && ahb_pend;
    check_val("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
    check_val("ahb_rvalid", 32'(ahb_rvalid), 32'(e_arv));
    if (!rst) begin
      check_val("cpu_rdata", cpu_rdata, e_crv ? cpu_pend_data : cpu_hold);
      check_val("ahb_rdata", ahb_rdata, e_arv ? ahb_pend_data : ahb_hold);
    end
    obs_cpu_gnt = cpu_gnt; obs_ahb_gnt = ahb_gnt;
    obs_cpu_rvalid = cpu_rvalid; obs_ahb_rvalid = ahb_rvalid;
    obs_cpu_rdata = cpu_rdata; obs_ahb_rdata = ahb_rdata;
    if (verbose && e_cg)
      $display("[TB] t=%0t CPU %s addr=%h wdata=%h", $time, cpu_we ? "WR" : "RD", cpu_addr, cpu_wdata);
    if (verbose && e_ag)
      $display("[TB] t=%0t AHB %s addr=%h wdata=%h", $time, ahb_we ? "WR" : "RD", ahb_addr, ahb_wdata);
    @(posedge clk);
    #1;
    if (rst) begin
      denied = 0; cpu_pend = 0; ahb_pend = 0; cpu_hold = '0; ahb_hold = '0;
    end else begin
      if (cpu_pend) cpu_hold = cpu_pend_data;
      if (ahb_pend) ahb_hold = ahb_pend_data;
      cpu_pend = 0; ahb_pend = 0;
      if (e_cg) begin
        last_valid = 1; last_addr = cpu_addr; last_din = cpu_wdata;
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else begin cpu_pend = 1; cpu_pend_data = ref_mem[cpu_addr]; end
      end
      if (e_ag) begin
        last_valid = 1; last_addr = ahb_addr; last_din = ahb_wdata;
        if (ahb_we) ref_mem[ahb_addr] = ahb_wdata;
        else begin ahb_pend = 1; ahb_pend_data = ref_mem[ahb_addr]; end
      end
      if (e_ag || !ahb_req) denied = 0;
      else if (denied < 15) denied++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [9:0] pattern;
    bit a_pend;
    logic a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wd;

    n_tests = 0; n_fail = 0; verbose = 1;
    denied = 0; cpu_pend = 0; ahb_pend = 0; cpu_hold = '0; ahb_hold = '0;
    cpu_pend_data = '0; ahb_pend_data = '0; last_valid = 0; last_addr = '0; last_din = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end

    // Reset with both ports requesting
    rst = 1;
    drive_cpu(1, 1, 11'h005, 32'h1111_1111);
    drive_ahb(1, 1, 11'h006, 32'h2222_2222);
    cycle();
    cycle();
    rst = 0;
    drive_cpu(0, 0, '0, '0);
    drive_ahb(0, 0, '0, '0);
    cycle();
    check_val("rst_cpu_rvalid", 32'(obs_cpu_rvalid), 32'd0);
    check_val("rst_cpu_rdata", obs_cpu_rdata, 32'd0);
    check_val("rst_ahb_rdata", obs_ahb_rdata, 32'd0);

    // CPU write then read back
    drive_cpu(1, 1, 11'h010, 32'hDEAD_BEEF); cycle();
    check_val("wr_cpu_gnt", 32'(obs_cpu_gnt), 32'd1);
    drive_cpu(1, 0, 11'h010, '0); cycle();
    check_val("rd_cpu_gnt", 32'(obs_cpu_gnt), 32'd1);
    drive_cpu(0, 0, '0, '0); cycle();
    check_val("rd_cpu_data", obs_cpu_rdata, 32'hDEAD_BEEF);
    cycle(); cycle();
    check_val("rd_cpu_held", obs_cpu_rdata, 32'hDEAD_BEEF);

    // Both requesting continuously: AHB wins every fifth cycle
    pattern = '0;
    drive_ahb(1, 0, 11'h020, '0);
    for (int i = 0; i < 10; i++) begin
      drive_cpu(1, 0, 11'(i), '0);
      cycle();
      pattern[i] = obs_ahb_gnt;
    end
    check_val("starve_pattern", 32'(pattern), 32'h210);
    drive_cpu(0, 0, '0, '0); drive_ahb(0, 0, '0, '0); cycle();

    // AHB read then CPU read in consecutive cycles
    drive_ahb(1, 1, 11'h7FF, 32'h1234_5678); cycle();
    drive_ahb(0, 0, '0, '0);
    drive_cpu(1, 1, 11'h001, 32'hA5A5_0001); cycle();
    drive_cpu(0, 0, '0, '0);
    drive_ahb(1, 0, 11'h7FF, '0); cycle();
    drive_ahb(0, 0, '0, '0);
    drive_cpu(1, 0, 11'h001, '0); cycle();
    check_val("ahb_rv_n1", 32'(obs_ahb_rvalid), 32'd1);
    check_val("ahb_rd_n1", obs_ahb_rdata, 32'h1234_5678);
    drive_cpu(0, 0, '0, '0); cycle();
    check_val("cpu_rv_n2", 32'(obs_cpu_rvalid), 32'd1);
    check_val("cpu_rd_n2", obs_cpu_rdata, 32'hA5A5_0001);
    check_val("ahb_rv_n2", 32'(obs_ahb_rvalid), 32'd0);

    // CPU read granted, then reset the next cycle
    drive_cpu(1, 0, 11'h010, '0); cycle();
    drive_cpu(0, 0, '0, '0);
    rst = 1; cycle();
    check_val("rstrd_cpu_rvalid", 32'(obs_cpu_rvalid), 32'd0);
    rst = 0; cycle();
    check_val("rstrd_cpu_rvalid2", 32'(obs_cpu_rvalid), 32'd0);
    check_val("rstrd_cpu_rdata", obs_cpu_rdata, 32'd0);

    // AHB idle while CPU streams, then a single AHB request
    for (int i = 0; i < 10; i++) begin
      drive_cpu(1, 0, 11'(i + 3), '0);
      cycle();
    end
    drive_ahb(1, 1, 11'h030, 32'hCAFE_F00D);
    n = 0;
    do begin
      drive_cpu(1, 0, 11'(n), '0);
      cycle();
      n++;
    end while (!obs_ahb_gnt && n < 20);
    check_val("ahb_wait_cycles", 32'(n), 32'd5);
    drive_cpu(0, 0, '0, '0); drive_ahb(0, 0, '0, '0); cycle();

    // Random traffic; AHB holds its request stable until granted
    verbose = 0;
    a_pend = 0; a_we = 0; a_addr = '0; a_wd = '0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!a_pend && $urandom_range(0, 2) == 0) begin
        a_pend = 1;
        a_we   = 1'($urandom_range(0, 1));
        a_addr = ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(0, 15));
        a_wd   = $urandom;
      end
      drive_ahb(a_pend, a_we, a_addr, a_wd);
      drive_cpu(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                11'($urandom_range(0, 15)), $urandom);
      cycle();
      if (obs_ahb_gnt) a_pend = 0;
    end
    rst = 0;
    drive_cpu(0, 0, '0, '0); drive_ahb(0, 0, '0, '0);
    cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
